// File: rtl/lc_req_pkg.sv
// Shared types and helpers for the lifecycle request assembler.
// The optional per-word parity check is enabled by defining LC_REQ_PARITY_EN.
package lc_req_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RX_TID,
        S_RX_AUTH,
        S_ISSUE,
        S_HOLD,
        S_ZERO,
        S_ERR
    } lc_req_state_e;

    localparam int unsigned ID_W_MAX = 1024;
    localparam logic [ID_W_MAX-1:0] ZERO_ID = '0;

    // Beat counter needs at least one bit even when an ID is a single word.
    function automatic int unsigned lc_beat_cnt_w(input int unsigned nw);
        return (nw <= 1) ? 1 : $clog2(nw);
    endfunction

endpackage

// File: rtl/lc_word_packer.sv
// One ID_W register assembled word by word at an indexed position,
// with a synchronous clear used for zeroization.
module lc_word_packer
    import lc_req_pkg::*;
#(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned ID_W   = 256,
    parameter int unsigned IDX_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic              we_i,
    input  logic              clr_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [ID_W-1:0]   id_o
);

    logic [ID_W-1:0] id_q, id_d;

    always_comb begin
        id_d = id_q;
        if (we_i) begin
            id_d[WORD_W*idx_i +: WORD_W] = wdata_i;
        end
        if (clr_i) begin
            id_d = ZERO_ID[ID_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            id_q <= ZERO_ID[ID_W-1:0];
        end else begin
            id_q <= id_d;
        end
    end

    assign id_o = id_q;

endmodule

// File: rtl/lc_request_assembler.sv
// Assembles a transition ID and an authentication ID from a host word stream,
// issues them to lifecycle protection, holds, then zeroizes. Optional parity: LC_REQ_PARITY_EN.
module lc_request_assembler
    import lc_req_pkg::*;
#(
    parameter int unsigned WORD_W         = 32,
    parameter int unsigned ID_W           = 256,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned HOLD_CYCLES    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              host_start,
    input  logic              host_abort,
    input  logic [WORD_W-1:0] host_wdata,
    input  logic              host_wparity,
    input  logic              host_wvalid,
    output logic              host_wready,
    output logic [ID_W-1:0]   lc_transition_id,
    output logic              lc_transition_request_in,
    output logic [ID_W-1:0]   lc_authentication_id,
    output logic              lc_authentication_valid,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned NW  = ID_W / WORD_W;
    localparam int unsigned BCW = lc_beat_cnt_w(NW);
    localparam int unsigned TW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned HW  = $clog2(HOLD_CYCLES + 1);

    lc_req_state_e  state_q, state_d;
    logic [BCW-1:0] beat_q, beat_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [HW-1:0]  hold_q, hold_d;
    logic           err_q, err_d;

    logic in_rx, accept, par_bad, store, last_beat, id_clr;

    assign in_rx       = (state_q == S_RX_TID) || (state_q == S_RX_AUTH);
    assign host_wready = in_rx & ~host_abort;
    assign accept      = host_wvalid & host_wready;
    assign last_beat   = (beat_q == BCW'(NW - 1));

`ifdef LC_REQ_PARITY_EN
    assign par_bad = accept & (^{host_wdata, host_wparity});
`else
    logic unused_parity;
    assign par_bad       = 1'b0;
    assign unused_parity = host_wparity;
`endif

    assign store = accept & ~par_bad;

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        timer_d = timer_q;
        hold_d  = hold_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (host_start) begin
                    state_d = S_RX_TID;
                    err_d   = 1'b0;
                    beat_d  = '0;
                    timer_d = '0;
                end
            end
            S_RX_TID, S_RX_AUTH: begin
                if (host_abort || par_bad) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end else if (accept) begin
                    timer_d = '0;
                    if (last_beat) begin
                        beat_d  = '0;
                        state_d = (state_q == S_RX_TID) ? S_RX_AUTH : S_ISSUE;
                    end else begin
                        beat_d = beat_q + BCW'(1);
                    end
                end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    // This idle cycle is the TIMEOUT_CYCLES-th since the last beat.
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_ISSUE: begin
                hold_d  = '0;
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (hold_q == HW'(HOLD_CYCLES - 1)) begin
                    state_d = S_ZERO;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            timer_q <= '0;
            hold_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            timer_q <= timer_d;
            hold_q  <= hold_d;
            err_q   <= err_d;
        end
    end

    // Clear on entry so the IDs already read zero during ZERO and ERR.
    assign id_clr = (state_d == S_ZERO) || (state_d == S_ERR);

    lc_word_packer #(.WORD_W(WORD_W), .ID_W(ID_W), .IDX_W(BCW)) u_tid (
        .clk     (clk),
        .rst     (rst),
        .idx_i   (beat_q),
        .we_i    (store && (state_q == S_RX_TID)),
        .clr_i   (id_clr),
        .wdata_i (host_wdata),
        .id_o    (lc_transition_id)
    );

    lc_word_packer #(.WORD_W(WORD_W), .ID_W(ID_W), .IDX_W(BCW)) u_auth (
        .clk     (clk),
        .rst     (rst),
        .idx_i   (beat_q),
        .we_i    (store && (state_q == S_RX_AUTH)),
        .clr_i   (id_clr),
        .wdata_i (host_wdata),
        .id_o    (lc_authentication_id)
    );

    assign lc_transition_request_in = (state_q == S_ISSUE);
    assign lc_authentication_valid  = (state_q == S_ISSUE) || (state_q == S_HOLD);
    assign busy                     = (state_q != S_IDLE);
    assign done                     = (state_q == S_ZERO);
    assign err                      = err_q;

endmodule

// File: tb/tb_lc_request_assembler.sv
// Directed and randomized bench for lc_request_assembler, checked against an
// ID-assembly and timing model derived from the transfer rules.
module tb_lc_request_assembler;

    localparam int WORD_W = 32;
    localparam int ID_W   = 256;
    localparam int NW     = ID_W / WORD_W;
    localparam int NB     = 2 * NW;
    localparam int TMO    = 8;
    localparam int HOLD   = 4;
`ifdef LC_REQ_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              host_start, host_abort, host_wparity, host_wvalid;
    logic [WORD_W-1:0] host_wdata;
    logic              host_wready;
    logic [ID_W-1:0]   tid, auth;
    logic              req, aval, busy, done, err;

    always #5 clk = ~clk;

    lc_request_assembler #(
        .WORD_W(WORD_W), .ID_W(ID_W), .TIMEOUT_CYCLES(TMO), .HOLD_CYCLES(HOLD)
    ) dut (
        .clk                      (clk),
        .rst                      (rst),
        .host_start               (host_start),
        .host_abort               (host_abort),
        .host_wdata               (host_wdata),
        .host_wparity             (host_wparity),
        .host_wvalid              (host_wvalid),
        .host_wready              (host_wready),
        .lc_transition_id         (tid),
        .lc_transition_request_in (req),
        .lc_authentication_id     (auth),
        .lc_authentication_valid  (aval),
        .busy                     (busy),
        .done                     (done),
        .err                      (err)
    );

    int errors = 0;
    int checks = 0;
    int req_seen = 0;
    int done_seen = 0;
    int n_complete = 0;

    always @(negedge clk) begin
        if (req)  req_seen++;
        if (done) done_seen++;
    end

    logic [WORD_W-1:0] words [NB];
    int                gaps  [NB];
    bit                bad   [NB];
    logic [ID_W-1:0]   exp_tid, exp_auth;

    task automatic chk(input string tag, input logic [ID_W-1:0] obs, input logic [ID_W-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [WORD_W-1:0] d);
        host_wvalid  = 1'b1;
        host_wdata   = d;
        host_wparity = ^d;
        tick();
        host_wvalid  = 1'b0;
    endtask

    task automatic start_xfer();
        host_start = 1'b1;
        tick();
        host_start = 1'b0;
    endtask

    // Expected IDs: word k of the stream lands at ID bit offset (k mod NW)*WORD_W.
    task automatic run_xfer(input bit start_in_hold, output bit completed);
        exp_tid   = '0;
        exp_auth  = '0;
        completed = 1'b0;
        start_xfer();
        chk("start_busy", busy, 1);
        chk("start_err_clear", err, 0);
        for (int k = 0; k < NB; k++) begin
            repeat (gaps[k]) tick();
            host_wvalid  = 1'b1;
            host_wdata   = words[k];
            host_wparity = (^words[k]) ^ bad[k];
            #1 chk("wready_rx", host_wready, 1);
            tick();
            host_wvalid = 1'b0;
            if (PAR_EN && bad[k]) begin
                chk("par_err", err, 1);
                chk("par_busy", busy, 1);
                chk("par_tid_zero", tid, 0);
                chk("par_auth_zero", auth, 0);
                chk("par_no_req", req, 0);
                tick();
                chk("par_idle", busy, 0);
                return;
            end
            if (k < NW) exp_tid[k*WORD_W +: WORD_W] = words[k];
            else        exp_auth[(k-NW)*WORD_W +: WORD_W] = words[k];
            chk("tid_assembly", tid, exp_tid);
            chk("auth_assembly", auth, exp_auth);
            chk("rx_no_err", err, 0);
            if (k < NB - 1) chk("rx_no_req", req, 0);
        end
        chk("req_pulse", req, 1);
        chk("issue_valid", aval, 1);
        for (int h = 0; h < HOLD; h++) begin
            if (start_in_hold && h == 1) host_start = 1'b1;
            tick();
            host_start = 1'b0;
            chk("hold_valid", aval, 1);
            chk("hold_req_low", req, 0);
            chk("hold_busy", busy, 1);
            chk("hold_tid", tid, exp_tid);
        end
        tick();
        chk("zero_done", done, 1);
        chk("zero_valid_low", aval, 0);
        chk("zero_tid", tid, 0);
        chk("zero_auth", auth, 0);
        if (start_in_hold) host_start = 1'b1;
        tick();
        host_start = 1'b0;
        chk("idle_done_low", done, 0);
        chk("idle_busy_low", busy, 0);
        completed = 1'b1;
    endtask

    task automatic clear_plan();
        for (int k = 0; k < NB; k++) begin
            gaps[k] = 0;
            bad[k]  = 1'b0;
        end
    endtask

    bit c;

    initial begin
        rst = 1'b1; host_start = 1'b0; host_abort = 1'b0;
        host_wdata = '0; host_wparity = 1'b0; host_wvalid = 1'b0;
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_req", req, 0);
        chk("rst_valid", aval, 0);
        chk("rst_tid", tid, 0);
        chk("rst_auth", auth, 0);
        chk("rst_wready", host_wready, 0);
        rst = 1'b0;
        tick();

        // Nominal transfer, with start ignored during HOLD and ZERO
        clear_plan();
        for (int k = 0; k < NB; k++) words[k] = 32'h1000_0000 + k;
        run_xfer(1'b1, c);
        if (c) n_complete++;
        chk("nom_completed", c, 1);

        // Word offered in IDLE is refused and not stored
        host_wvalid = 1'b1; host_wdata = 32'hDEAD_BEEF; host_wparity = ^host_wdata;
        #1 chk("idle_wready", host_wready, 0);
        tick();
        host_wvalid = 1'b0;
        chk("idle_tid", tid, 0);
        chk("idle_busy", busy, 0);

        // Abort together with beat 5
        start_xfer();
        for (int k = 0; k < 5; k++) beat(32'hA000_0000 + k);
        host_wvalid = 1'b1; host_wdata = 32'hA000_0005; host_wparity = ^host_wdata;
        host_abort = 1'b1;
        #1 chk("abort_wready", host_wready, 0);
        tick();
        host_abort = 1'b0; host_wvalid = 1'b0;
        chk("abort_err", err, 1);
        chk("abort_busy", busy, 1);
        chk("abort_tid", tid, 0);
        chk("abort_req", req, 0);
        tick();
        chk("abort_idle", busy, 0);
        host_abort = 1'b1;
        tick();
        host_abort = 1'b0;
        chk("abort_idle_ignored", busy, 0);
        chk("err_sticky", err, 1);
        start_xfer();
        chk("restart_err_clear", err, 0);
        host_abort = 1'b1;
        tick();
        host_abort = 1'b0;
        tick();

        // Timeout: three beats then a stall of TMO cycles
        start_xfer();
        for (int k = 0; k < 3; k++) beat(32'hC000_0000 + k);
        for (int i = 1; i < TMO; i++) begin
            tick();
            chk("stall_no_err", err, 0);
        end
        tick();
        chk("timeout_err", err, 1);
        chk("timeout_busy", busy, 1);
        chk("timeout_tid", tid, 0);
        tick();
        chk("timeout_idle", busy, 0);

        // Reset in RX_AUTH after beat 10
        start_xfer();
        for (int k = 0; k <= 10; k++) beat(32'h5000_0000 + k);
        chk("pre_rst_busy", busy, 1);
        chk("pre_rst_auth", auth[2*WORD_W +: WORD_W], 32'h5000_000A);
        rst = 1'b1;
        tick();
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_tid", tid, 0);
        chk("mid_rst_auth", auth, 0);
        chk("mid_rst_flags", {req, aval, done, err, host_wready}, 0);
        rst = 1'b0;
        tick();

        // Randomized transfers; the first one stalls TMO-1 cycles before a beat
        for (int r = 0; r < 3; r++) begin
            clear_plan();
            for (int k = 0; k < NB; k++) begin
                words[k] = $urandom;
                gaps[k]  = $urandom_range(0, 3);
            end
            if (r == 0) gaps[5] = TMO - 1;
            run_xfer(1'b0, c);
            if (c) n_complete++;
            chk("rand_completed", c, 1);
        end

        // Wrong parity on beat 3
        clear_plan();
        for (int k = 0; k < NB; k++) words[k] = 32'h2000_0000 + k;
        bad[3] = 1'b1;
        run_xfer(1'b0, c);
        if (c) n_complete++;
        chk("parity_outcome", c, !PAR_EN);

        tick();
        chk("req_pulse_count", req_seen, n_complete);
        chk("done_pulse_count", done_seen, n_complete);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
